// File: rtl/ec_pkg.sv
// rtl/ec_pkg.sv - shared state encoding and modular add/sub helpers for the EC point engine
package ec_pkg;

  typedef enum logic [3:0] {
    IDLE, CHK, NUM0, NUM1, INV, SLOPE, X0, X1, Y0, Y1, DONE
  } ec_state_t;

  // Helpers work on a wide container; callers zero-extend W-bit operands and the modulus.
  localparam int MAXW = 32;

  function automatic logic [MAXW-1:0] mod_add(input logic [MAXW-1:0] x,
                                               input logic [MAXW-1:0] y,
                                               input logic [MAXW-1:0] p);
    logic [MAXW:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= {1'b0, p}) ? MAXW'(s - {1'b0, p}) : MAXW'(s);
  endfunction

  function automatic logic [MAXW-1:0] mod_sub(input logic [MAXW-1:0] x,
                                               input logic [MAXW-1:0] y,
                                               input logic [MAXW-1:0] p);
    return (x >= y) ? (x - y) : (x + p - y);
  endfunction

endpackage

// File: rtl/ec_mod_mul.sv
// rtl/ec_mod_mul.sv - combinational (a*b) mod P with a full 2W-bit product
module ec_mod_mul #(
  parameter int          W = 8,
  parameter logic [W-1:0] P = 8'd251
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] r
);

  localparam logic [2*W-1:0] P_EXT = {{W{1'b0}}, P};

  logic [2*W-1:0] prod;

  always_comb begin
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    r    = W'(prod % P_EXT);
  end

endmodule

// File: rtl/ec_point_add_ctrl.sv
// rtl/ec_point_add_ctrl.sv - sequenced affine point add/double over GF(P) sharing one modular multiplier
module ec_point_add_ctrl
  import ec_pkg::*;
#(
  parameter int           W      = 8,
  parameter logic [W-1:0] P      = 8'd251,
  parameter logic [W-1:0] A_COEF = 8'd0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] ax,
  input  logic [W-1:0] ay,
  input  logic         a_inf,
  input  logic [W-1:0] bx,
  input  logic [W-1:0] by,
  input  logic         b_inf,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] rx,
  output logic [W-1:0] ry,
  output logic         r_inf
);

  localparam int           CW  = $clog2(2 * W);
  localparam logic [W-1:0] EXP = P - W'(2);

  function automatic logic [W-1:0] fadd(input logic [W-1:0] x, input logic [W-1:0] y);
    return W'(mod_add(MAXW'(x), MAXW'(y), MAXW'(P)));
  endfunction

  function automatic logic [W-1:0] fsub(input logic [W-1:0] x, input logic [W-1:0] y);
    return W'(mod_sub(MAXW'(x), MAXW'(y), MAXW'(P)));
  endfunction

  ec_state_t state, state_n;

  logic [W-1:0]  ax_q, ay_q, bx_q, by_q;
  logic          a_inf_q, b_inf_q;
  logic [W-1:0]  num_q, den_q, t_q, acc_q, s_q, x3_q, d_q;
  logic [CW-1:0] cnt_q;

  logic [W-1:0] mul_a, mul_b, mul_r;
  logic         same_x, special, sp_inf;
  logic [W-1:0] sp_x, sp_y;
  logic [W-1:0] exp_sh;
  logic         ebit, inv_last;

  ec_mod_mul #(.W(W), .P(P)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .r (mul_r)
  );

  // Special-case resolution, consumed only in CHK.
  always_comb begin
    same_x  = (ax_q == bx_q);
    special = 1'b1;
    sp_inf  = 1'b0;
    sp_x    = '0;
    sp_y    = '0;
    if (a_inf_q && b_inf_q) begin
      sp_inf = 1'b1;
    end else if (a_inf_q) begin
      sp_x = bx_q;
      sp_y = by_q;
    end else if (b_inf_q) begin
      sp_x = ax_q;
      sp_y = ay_q;
    end else if (same_x && (fadd(ay_q, by_q) == '0)) begin
      sp_inf = 1'b1;
    end else begin
      special = 1'b0;
    end
  end

  // Even counts square, odd counts multiply by den or 1 so every exponent bit costs two cycles.
  always_comb begin
    exp_sh   = EXP << (cnt_q >> 1);
    ebit     = exp_sh[W-1];
    inv_last = (cnt_q == CW'(2 * W - 1));
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      NUM0: begin
        mul_a = ax_q;
        mul_b = ax_q;
      end
      INV: begin
        mul_a = acc_q;
        mul_b = cnt_q[0] ? (ebit ? den_q : W'(1)) : acc_q;
      end
      SLOPE: begin
        mul_a = num_q;
        mul_b = acc_q;
      end
      X0: begin
        mul_a = s_q;
        mul_b = s_q;
      end
      Y1: begin
        mul_a = s_q;
        mul_b = d_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE:    if (start) state_n = CHK;
      CHK:     state_n = special ? DONE : NUM0;
      NUM0:    state_n = NUM1;
      NUM1:    state_n = INV;
      INV:     if (inv_last) state_n = SLOPE;
      SLOPE:   state_n = X0;
      X0:      state_n = X1;
      X1:      state_n = Y0;
      Y0:      state_n = Y1;
      Y1:      state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy = (state != IDLE) && (state != DONE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ax_q    <= '0;
      ay_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      a_inf_q <= 1'b0;
      b_inf_q <= 1'b0;
      num_q   <= '0;
      den_q   <= '0;
      t_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      x3_q    <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      rx      <= '0;
      ry      <= '0;
      r_inf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ax_q    <= ax;
            ay_q    <= ay;
            bx_q    <= bx;
            by_q    <= by;
            a_inf_q <= a_inf;
            b_inf_q <= b_inf;
          end
        end
        CHK: begin
          if (special) begin
            rx    <= sp_x;
            ry    <= sp_y;
            r_inf <= sp_inf;
          end
        end
        NUM0: begin
          if (same_x) t_q <= mul_r;
          else        num_q <= fsub(by_q, ay_q);
        end
        NUM1: begin
          acc_q <= W'(1);
          cnt_q <= '0;
          if (same_x) begin
            num_q <= fadd(fadd(fadd(t_q, t_q), t_q), A_COEF);
            den_q <= fadd(ay_q, ay_q);
          end else begin
            den_q <= fsub(bx_q, ax_q);
          end
        end
        INV: begin
          acc_q <= mul_r;
          cnt_q <= cnt_q + CW'(1);
        end
        SLOPE: s_q  <= mul_r;
        X0:    t_q  <= mul_r;
        X1:    x3_q <= fsub(fsub(t_q, ax_q), bx_q);
        Y0:    d_q  <= fsub(ax_q, x3_q);
        Y1: begin
          rx    <= x3_q;
          ry    <= fsub(mul_r, ay_q);
          r_inf <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ec_point_add_ctrl.sv
// tb/tb_ec_point_add_ctrl.sv - self-checking bench for ec_point_add_ctrl on y^2 = x^3 + 2x + 2 over GF(17)
module tb_ec_point_add_ctrl;

  localparam int           W       = 5;
  localparam logic [W-1:0] P       = 5'd17;
  localparam logic [W-1:0] A_COEF  = 5'd2;
  localparam int           PI      = 17;
  localparam int           AI      = 2;
  localparam int           LAT_GEN = 8 + 2 * W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] ax = '0, ay = '0, bx = '0, by = '0;
  logic         a_inf = 1'b0, b_inf = 1'b0;
  logic         busy, done, r_inf;
  logic [W-1:0] rx, ry;

  always #5 clk = ~clk;

  ec_point_add_ctrl #(.W(W), .P(P), .A_COEF(A_COEF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .ax    (ax),
    .ay    (ay),
    .a_inf (a_inf),
    .bx    (bx),
    .by    (by),
    .b_inf (b_inf),
    .busy  (busy),
    .done  (done),
    .rx    (rx),
    .ry    (ry),
    .r_inf (r_inf)
  );

  typedef struct {
    int ax, ay, ai, bx, by, bi;
    int rx, ry, ri, lat;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: textbook affine formulas, inverse by exhaustive search.
  function automatic vec_t ref_model(input vec_t v);
    vec_t r;
    int num, den, inv, s, x3, y3;
    r = v;
    r.rx = 0; r.ry = 0; r.ri = 0; r.lat = 1;
    num = 0; den = 0;
    if (v.ai != 0 && v.bi != 0) begin
      r.ri = 1;
    end else if (v.ai != 0) begin
      r.rx = v.bx; r.ry = v.by;
    end else if (v.bi != 0) begin
      r.rx = v.ax; r.ry = v.ay;
    end else if (v.ax == v.bx && (v.ay + v.by) % PI == 0) begin
      r.ri = 1;
    end else begin
      r.lat = LAT_GEN;
      if (v.ax == v.bx) begin
        num = (3 * v.ax * v.ax + AI) % PI;
        den = (2 * v.ay) % PI;
      end else begin
        num = (v.by - v.ay + PI) % PI;
        den = (v.bx - v.ax + PI) % PI;
      end
      inv = 0;
      for (int k = 1; k < PI; k++) if ((den * k) % PI == 1) inv = k;
      s  = (num * inv) % PI;
      x3 = ((s * s) % PI + 2 * PI - v.ax - v.bx) % PI;
      y3 = ((s * ((v.ax - x3 + PI) % PI)) % PI + PI - v.ay) % PI;
      r.rx = x3; r.ry = y3;
    end
    return r;
  endfunction

  task automatic drive(input vec_t v);
    ax = W'(v.ax); ay = W'(v.ay); a_inf = (v.ai != 0);
    bx = W'(v.bx); by = W'(v.by); b_inf = (v.bi != 0);
  endtask

  task automatic launch(input vec_t v);
    drive(v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat = -1;
    bcnt = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat, input int bcnt);
    check({tag, "_lat"}, lat, v.lat);
    check({tag, "_busy_cycles"}, bcnt, v.lat - 1);
    check({tag, "_busy_at_done"}, int'(busy), 0);
    check({tag, "_rx"}, int'(rx), v.rx);
    check({tag, "_ry"}, int'(ry), v.ry);
    check({tag, "_rinf"}, int'(r_inf), v.ri);
  endtask

  task automatic run_check(input string tag, input vec_t v);
    int lat, bcnt;
    launch(v);
    check({tag, "_busy_start"}, int'(busy), 1);
    wait_done(lat, bcnt);
    check_result(tag, v, lat, bcnt);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_rx_hold"}, int'(rx), v.rx);
    check({tag, "_ry_hold"}, int'(ry), v.ry);
  endtask

  vec_t tbl[6];
  vec_t v;
  int   px[$], py[$];
  int   lat, bcnt, got_done, i, j, sel;

  initial begin
    tbl[0] = '{5, 1, 0, 5, 1, 0, 6, 3, 0, LAT_GEN};
    tbl[1] = '{5, 1, 0, 6, 3, 0, 10, 6, 0, LAT_GEN};
    tbl[2] = '{5, 1, 0, 5, 16, 0, 0, 0, 1, 1};
    tbl[3] = '{3, 4, 1, 6, 3, 0, 6, 3, 0, 1};
    tbl[4] = '{10, 6, 0, 2, 7, 1, 10, 6, 0, 1};
    tbl[5] = '{10, 6, 1, 6, 3, 1, 0, 0, 1, 1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_rx", int'(rx), 0);
    check("reset_ry", int'(ry), 0);
    check("reset_rinf", int'(r_inf), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) run_check($sformatf("vec%0d", t), tbl[t]);

    for (int x = 0; x < PI; x++)
      for (int y = 0; y < PI; y++)
        if ((y * y) % PI == (x * x * x + AI * x + 2) % PI) begin
          px.push_back(x);
          py.push_back(y);
        end

    for (int n = 0; n < 40; n++) begin
      i = $urandom_range(0, px.size() - 1);
      j = $urandom_range(0, px.size() - 1);
      sel = $urandom_range(0, 7);
      v = '{px[i], py[i], 0, px[j], py[j], 0, 0, 0, 0, 0};
      if (sel == 0) begin v.bx = px[i]; v.by = py[i]; end
      if (sel == 1) begin v.bx = px[i]; v.by = (PI - py[i]) % PI; end
      if (sel == 2) v.ai = 1;
      if (sel == 3) v.bi = 1;
      if (sel == 4) begin v.ai = 1; v.bi = 1; end
      v = ref_model(v);
      run_check($sformatf("rnd%0d", n), v);
    end

    // Reset in the middle of an operation, with ignored start pulses along the way.
    run_check("pre_abort", tbl[0]);
    launch(tbl[1]);
    got_done = 0;
    for (int c = 1; c <= 12; c++) begin
      if (c == 3 || c == 10) begin
        drive(tbl[4]);
        start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) got_done = 1;
      if (c == 11) check("abort_rx_held", int'(rx), 6);
    end
    check("abort_busy_before", int'(busy), 1);
    check("abort_no_done", got_done, 0);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_rx", int'(rx), 0);
    check("abort_ry", int'(ry), 0);
    check("abort_rinf", int'(r_inf), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_check("post_abort", tbl[0]);

    // Start during the done cycle is ignored; one cycle later it is accepted.
    launch(tbl[0]);
    wait_done(lat, bcnt);
    check_result("b2b_first", tbl[0], lat, bcnt);
    drive(tbl[2]);
    start = 1'b1;
    @(posedge clk); #1;
    check("b2b_ignored_busy", int'(busy), 0);
    check("b2b_ignored_done", int'(done), 0);
    drive(tbl[1]);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_accepted_busy", int'(busy), 1);
    wait_done(lat, bcnt);
    check_result("b2b_second", tbl[1], lat, bcnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
